fv_bank_rd_requester: RTL and testbench

- Initiator side of the per-bank request interface into the big FV bank controller. One instance per FV bank.
- Accepts read requests from Edge PEs and issues them to the bank one at a time, holding each until the bank grants it.
- Tracks in-flight requests in order and buffers the returned FV lines.
- Delivers each line to the requesting PE over a valid/ready handshake, tagged with that PE's id.

---
 rtl/fv_bank_rd_requester.sv | 214 +++++++++++++++++++++
 tb/tb_fv_bank_rd_requester.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fv_bank_rd_requester.sv
// fv_bank_rd_requester
// Per-bank read initiator into the FV bank controller. Accepts Edge PE read
// requests, issues them to the bank one at a time, remembers the requester id
// of every granted request in order (tag FIFO), buffers returned lines
// (return FIFO) and hands each line back to its PE tagged with the PE id.
//
// Handshakes: on pe_req and pe_rsp a transfer happens on a rising clk edge
// where valid and ready are both 1; a producer holds valid and its payload
// stable until that edge. On the bank side bank_grant plays the role of
// ready for bank_req_valid/bank_req_addr. pe_req_ready is combinational in
// bank_grant and flush; pe_rsp_valid/data/id come straight from registers.
module fv_bank_rd_requester #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 64,
  parameter int PE_ID_W = 2,
  parameter int MAX_OUT = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pe_req_valid,
  input  logic [ADDR_W-1:0]        pe_req_addr,
  input  logic [PE_ID_W-1:0]       pe_req_id,
  output logic                     pe_req_ready,
  output logic                     bank_req_valid,
  output logic [ADDR_W-1:0]        bank_req_addr,
  input  logic                     bank_grant,
  input  logic                     bank_rsp_valid,
  input  logic [DATA_W-1:0]        bank_rsp_data,
  output logic                     pe_rsp_valid,
  output logic [DATA_W-1:0]        pe_rsp_data,
  output logic [PE_ID_W-1:0]       pe_rsp_id,
  input  logic                     pe_rsp_ready,
  input  logic                     flush,
  output logic                     flush_done,
  output logic [$clog2(MAX_OUT):0] outstanding,
  output logic                     err_unexp,
  output logic [1:0]               state_dbg
);

  localparam int PW = $clog2(MAX_OUT);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;

  logic                hold_valid;
  logic [ADDR_W-1:0]   hold_addr;
  logic [PE_ID_W-1:0]  hold_id;

  logic [CW-1:0]       cnt;

  logic [PE_ID_W-1:0]  tag_mem [MAX_OUT];
  logic [PW-1:0]       tag_wr;
  logic [PW-1:0]       tag_rd;
  logic [CW-1:0]       tag_cnt;

  logic [PE_ID_W-1:0]  ret_id_mem   [MAX_OUT];
  logic [DATA_W-1:0]   ret_data_mem [MAX_OUT];
  logic [PW-1:0]       ret_wr;
  logic [PW-1:0]       ret_rd;
  logic [CW-1:0]       ret_cnt;

  logic                req_accept;
  logic                bank_take;
  logic                tag_empty;
  logic                tag_push;
  logic                tag_pop;
  logic                ret_push;
  logic                ret_pop;
  logic                drained;

  // Credit is reserved at acceptance, so both FIFOs plus the hold register can
  // never hold more than MAX_OUT entries; no full checks are needed on push.
  // Ready is also forced low while reset is asserted so every output reads 0.
  assign pe_req_ready = reset
                      & (cnt < CW'(MAX_OUT))
                      & (~hold_valid | bank_grant)
                      & (state_q != S_DRAIN)
                      & ~flush;

  assign req_accept = pe_req_valid & pe_req_ready;
  assign bank_take  = hold_valid & bank_grant;
  assign tag_empty  = (tag_cnt == '0);
  assign tag_push   = bank_take;
  assign tag_pop    = bank_rsp_valid & ~tag_empty;
  assign ret_push   = tag_pop;
  assign ret_pop    = pe_rsp_valid & pe_rsp_ready;
  assign drained    = ~hold_valid & tag_empty & (ret_cnt == '0);

  assign bank_req_valid = hold_valid;
  assign bank_req_addr  = hold_addr;
  assign pe_rsp_valid   = (ret_cnt != '0);
  assign pe_rsp_data    = pe_rsp_valid ? ret_data_mem[ret_rd] : '0;
  assign pe_rsp_id      = pe_rsp_valid ? ret_id_mem[ret_rd]   : '0;
  assign outstanding    = cnt;
  assign state_dbg      = state_q;

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state and the one-cycle drain-complete pulse.
  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (flush)           state_d = S_DRAIN;
        else if (req_accept) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (flush)                         state_d = S_DRAIN;
        else if (bank_take && !req_accept) state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (drained) begin
          flush_done = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Hold register: loads on accept, empties when the bank grants it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_valid <= 1'b0;
      hold_addr  <= '0;
      hold_id    <= '0;
    end else if (req_accept) begin
      hold_valid <= 1'b1;
      hold_addr  <= pe_req_addr;
      hold_id    <= pe_req_id;
    end else if (bank_take) begin
      hold_valid <= 1'b0;
    end
  end

  // Credit counter: up on PE accept, down on PE response handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else begin
      case ({req_accept, ret_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Tag FIFO pointers and occupancy (push on grant, pop on bank response).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_wr  <= '0;
      tag_rd  <= '0;
      tag_cnt <= '0;
    end else begin
      if (tag_push) tag_wr <= tag_wr + PW'(1);
      if (tag_pop)  tag_rd <= tag_rd + PW'(1);
      case ({tag_push, tag_pop})
        2'b10:   tag_cnt <= tag_cnt + CW'(1);
        2'b01:   tag_cnt <= tag_cnt - CW'(1);
        default: tag_cnt <= tag_cnt;
      endcase
    end
  end

  // Tag FIFO storage: requester id of each granted request, in grant order.
  always_ff @(posedge clk) begin
    if (tag_push) tag_mem[tag_wr] <= hold_id;
  end

  // Return FIFO pointers and occupancy (push on matched response, pop on PE handshake).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ret_wr  <= '0;
      ret_rd  <= '0;
      ret_cnt <= '0;
    end else begin
      if (ret_push) ret_wr <= ret_wr + PW'(1);
      if (ret_pop)  ret_rd <= ret_rd + PW'(1);
      case ({ret_push, ret_pop})
        2'b10:   ret_cnt <= ret_cnt + CW'(1);
        2'b01:   ret_cnt <= ret_cnt - CW'(1);
        default: ret_cnt <= ret_cnt;
      endcase
    end
  end

  // Return FIFO storage: {id, line} pairs waiting for the PE.
  always_ff @(posedge clk) begin
    if (ret_push) begin
      ret_id_mem[ret_wr]   <= tag_mem[tag_rd];
      ret_data_mem[ret_wr] <= bank_rsp_data;
    end
  end

  // Sticky flag: a bank response arrived with no granted request to match it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          err_unexp <= 1'b0;
    else if (bank_rsp_valid && tag_empty) err_unexp <= 1'b1;
  end

endmodule

// File: tb/tb_fv_bank_rd_requester.sv
// Testbench for fv_bank_rd_requester: table of single transactions plus
// hand-written multi-cycle sequences; returned lines are checked against an
// expected queue filled from the bench's own model of accepted/granted requests.
module tb_fv_bank_rd_requester;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 64;
  localparam int PE_ID_W = 2;
  localparam int MAX_OUT = 4;
  localparam int RW      = PE_ID_W + DATA_W;
  localparam int ST_IDLE  = 0;
  localparam int ST_DRAIN = 2;

  typedef struct {
    logic [ADDR_W-1:0]  addr;
    logic [PE_ID_W-1:0] id;
    logic [DATA_W-1:0]  data;
    int                 gnt_wait;
    int                 rsp_wait;
    int                 rdy_wait;
    logic [PE_ID_W-1:0] exp_id;
    logic [DATA_W-1:0]  exp_data;
    logic [ADDR_W-1:0]  exp_bank_addr;
  } vec_t;

  logic                     clk;
  logic                     reset;
  logic                     pe_req_valid;
  logic [ADDR_W-1:0]        pe_req_addr;
  logic [PE_ID_W-1:0]       pe_req_id;
  logic                     pe_req_ready;
  logic                     bank_req_valid;
  logic [ADDR_W-1:0]        bank_req_addr;
  logic                     bank_grant;
  logic                     bank_rsp_valid;
  logic [DATA_W-1:0]        bank_rsp_data;
  logic                     pe_rsp_valid;
  logic [DATA_W-1:0]        pe_rsp_data;
  logic [PE_ID_W-1:0]       pe_rsp_id;
  logic                     pe_rsp_ready;
  logic                     flush;
  logic                     flush_done;
  logic [$clog2(MAX_OUT):0] outstanding;
  logic                     err_unexp;
  logic [1:0]               state_dbg;

  int n_vec = 0;
  int n_err = 0;
  int hs_cnt = 0;
  int exp_cnt = 0;
  logic stall_q = 1'b0;
  logic [RW-1:0] stall_val = '0;

  logic [RW-1:0]      exp_q[$];
  logic [ADDR_W-1:0]  acc_addr_q[$];
  logic [PE_ID_W-1:0] acc_id_q[$];
  logic [PE_ID_W-1:0] gnt_id_q[$];

  fv_bank_rd_requester #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PE_ID_W(PE_ID_W), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk(clk), .reset(reset),
    .pe_req_valid(pe_req_valid), .pe_req_addr(pe_req_addr), .pe_req_id(pe_req_id),
    .pe_req_ready(pe_req_ready),
    .bank_req_valid(bank_req_valid), .bank_req_addr(bank_req_addr), .bank_grant(bank_grant),
    .bank_rsp_valid(bank_rsp_valid), .bank_rsp_data(bank_rsp_data),
    .pe_rsp_valid(pe_rsp_valid), .pe_rsp_data(pe_rsp_data), .pe_rsp_id(pe_rsp_id),
    .pe_rsp_ready(pe_rsp_ready),
    .flush(flush), .flush_done(flush_done),
    .outstanding(outstanding), .err_unexp(err_unexp), .state_dbg(state_dbg)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: got timeout required finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string name);
    chk(name, 128'({pe_req_ready, bank_req_valid, bank_req_addr, pe_rsp_valid, pe_rsp_data,
                    pe_rsp_id, flush_done, outstanding, err_unexp, state_dbg}), 128'(0));
  endtask

  // Advance to the drive point of the next cycle / let combinational outputs settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Hold pe_rsp_ready high until n more handshakes happen, bounded.
  task automatic drain(input int n);
    int target;
    int i;
    target = hs_cnt + n;
    i = 0;
    pe_rsp_ready = 1'b1;
    while (hs_cnt < target && i < 40) begin
      step();
      i++;
    end
    pe_rsp_ready = 1'b0;
    chk("drain_count", 128'(hs_cnt), 128'(target));
  endtask

  // Scoreboard and model, sampled on the falling edge.
  always @(negedge clk) begin
    logic acc;
    logic hs;
    logic [RW-1:0] e;
    logic [PE_ID_W-1:0] tid;
    logic [ADDR_W-1:0] ea;
    if (!reset) begin
      exp_q.delete();
      acc_addr_q.delete();
      acc_id_q.delete();
      gnt_id_q.delete();
      exp_cnt = 0;
      stall_q = 1'b0;
    end else begin
      acc = pe_req_valid & pe_req_ready;
      hs  = pe_rsp_valid & pe_rsp_ready;
      chk("outstanding", 128'(outstanding), 128'(exp_cnt));
      if (stall_q) begin
        chk("rsp_held_valid", 128'(pe_rsp_valid), 128'(1));
        chk("rsp_held_stable", 128'({pe_rsp_id, pe_rsp_data}), 128'(stall_val));
      end
      stall_q   = pe_rsp_valid & ~pe_rsp_ready;
      stall_val = {pe_rsp_id, pe_rsp_data};
      if (hs) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 128'(pe_rsp_valid), 128'(0));
        end else begin
          e = exp_q.pop_front();
          chk("rsp_id_data", 128'({pe_rsp_id, pe_rsp_data}), 128'(e));
        end
      end
      if (bank_rsp_valid && gnt_id_q.size() > 0) begin
        tid = gnt_id_q.pop_front();
        exp_q.push_back({tid, bank_rsp_data});
      end
      if (bank_req_valid && bank_grant) begin
        if (acc_addr_q.size() == 0) begin
          chk("grant_without_req", 128'(bank_req_valid), 128'(0));
        end else begin
          ea = acc_addr_q.pop_front();
          chk("bank_addr", 128'(bank_req_addr), 128'(ea));
          gnt_id_q.push_back(acc_id_q.pop_front());
        end
      end
      if (acc) begin
        acc_addr_q.push_back(pe_req_addr);
        acc_id_q.push_back(pe_req_id);
      end
      exp_cnt = exp_cnt + (acc ? 1 : 0) - (hs ? 1 : 0);
    end
  end

  // Stimulus.
  initial begin
    vec_t vecs[6];
    logic [PE_ID_W-1:0] t2_ids[5];
    logic [DATA_W-1:0] dbase;

    vecs[0] = '{8'h00, 2'd0, 64'h0, 0, 0, 0, 2'd0, 64'h0, 8'h00};
    vecs[1] = '{8'hFF, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1, 2, 3, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF};
    vecs[2] = '{8'h5A, 2'd2, 64'h0123_4567_89AB_CDEF, 3, 0, 1, 2'd2, 64'h0123_4567_89AB_CDEF, 8'h5A};
    vecs[3] = '{8'hA5, 2'd1, 64'hDEAD_BEEF_CAFE_F00D, 0, 4, 0, 2'd1, 64'hDEAD_BEEF_CAFE_F00D, 8'hA5};
    vecs[4] = '{8'h3C, 2'd0, 64'h8000_0000_0000_0001, 2, 1, 5, 2'd0, 64'h8000_0000_0000_0001, 8'h3C};
    vecs[5] = '{8'hC3, 2'd3, 64'h7FFF_0000_FFFF_0001, 5, 3, 2, 2'd3, 64'h7FFF_0000_FFFF_0001, 8'hC3};
    t2_ids[0] = 2'd3; t2_ids[1] = 2'd0; t2_ids[2] = 2'd2; t2_ids[3] = 2'd1; t2_ids[4] = 2'd3;
    dbase = 64'hD0D0_0000_0000_0000;

    reset = 1'b0;
    pe_req_valid = 1'b0; pe_req_addr = '0; pe_req_id = '0;
    bank_grant = 1'b0; bank_rsp_valid = 1'b0; bank_rsp_data = '0;
    pe_rsp_ready = 1'b0; flush = 1'b0;

    // Reset state.
    repeat (2) step();
    settle();
    chk_zero("reset_outputs");
    reset = 1'b1;
    settle();
    chk("rel_ready", 128'(pe_req_ready), 128'(1));
    chk("rel_state", 128'(state_dbg), 128'(ST_IDLE));

    // Single request, grant next cycle, response two cycles after grant.
    step(); pe_req_valid = 1'b1; pe_req_addr = 8'h12; pe_req_id = 2'd1; settle();
    chk("t1_ready", 128'(pe_req_ready), 128'(1));
    step(); pe_req_valid = 1'b0; bank_grant = 1'b1; settle();
    chk("t1_breq_valid", 128'(bank_req_valid), 128'(1));
    chk("t1_breq_addr", 128'(bank_req_addr), 128'(8'h12));
    step(); bank_grant = 1'b0; settle();
    chk("t1_breq_drop", 128'(bank_req_valid), 128'(0));
    step(); bank_rsp_valid = 1'b1; bank_rsp_data = 64'hA5A5; settle();
    chk("t1_rsp_not_yet", 128'(pe_rsp_valid), 128'(0));
    step(); bank_rsp_valid = 1'b0; settle();
    chk("t1_rsp_valid", 128'(pe_rsp_valid), 128'(1));
    chk("t1_rsp_data", 128'(pe_rsp_data), 128'(64'hA5A5));
    chk("t1_rsp_id", 128'(pe_rsp_id), 128'(1));
    pe_rsp_ready = 1'b1;
    step(); pe_rsp_ready = 1'b0; settle();
    chk("t1_rsp_gone", 128'(pe_rsp_valid), 128'(0));
    chk("t1_outstanding", 128'(outstanding), 128'(0));

    // Table of single transactions with varied grant/response/ready delays.
    foreach (vecs[v]) begin
      step(); pe_req_valid = 1'b1; pe_req_addr = vecs[v].addr; pe_req_id = vecs[v].id; settle();
      chk("vec_ready", 128'(pe_req_ready), 128'(1));
      step(); pe_req_valid = 1'b0; bank_grant = 1'b0;
      for (int w = 0; w < vecs[v].gnt_wait; w++) begin
        settle();
        chk("vec_hold_addr", 128'(bank_req_addr), 128'(vecs[v].exp_bank_addr));
        step();
      end
      bank_grant = 1'b1; settle();
      chk("vec_breq_valid", 128'(bank_req_valid), 128'(1));
      chk("vec_breq_addr", 128'(bank_req_addr), 128'(vecs[v].exp_bank_addr));
      step(); bank_grant = 1'b0;
      for (int w = 0; w < vecs[v].rsp_wait; w++) step();
      bank_rsp_valid = 1'b1; bank_rsp_data = vecs[v].data;
      step(); bank_rsp_valid = 1'b0; settle();
      chk("vec_rsp_valid", 128'(pe_rsp_valid), 128'(1));
      chk("vec_rsp_id", 128'(pe_rsp_id), 128'(vecs[v].exp_id));
      chk("vec_rsp_data", 128'(pe_rsp_data), 128'(vecs[v].exp_data));
      for (int w = 0; w < vecs[v].rdy_wait; w++) step();
      settle();
      chk("vec_rsp_late_id", 128'(pe_rsp_id), 128'(vecs[v].exp_id));
      pe_rsp_ready = 1'b1;
      step(); pe_rsp_ready = 1'b0; settle();
      chk("vec_rsp_gone", 128'(pe_rsp_valid), 128'(0));
      chk("vec_outstanding", 128'(outstanding), 128'(0));
    end

    // Five back-to-back requests with grant high: only MAX_OUT accepted.
    step(); bank_grant = 1'b1;
    for (int k = 0; k < 5; k++) begin
      pe_req_valid = 1'b1; pe_req_addr = 8'h20 + 8'(k); pe_req_id = t2_ids[k]; settle();
      chk("t2_ready", 128'(pe_req_ready), 128'(k < 4));
      if (k == 4) chk("t2_outstanding_full", 128'(outstanding), 128'(4));
      step();
    end
    pe_req_valid = 1'b0; bank_grant = 1'b0;
    // Four in-order responses with the PE stalled for 10 cycles.
    for (int k = 0; k < 4; k++) begin
      bank_rsp_valid = 1'b1; bank_rsp_data = dbase + 64'(k);
      step();
    end
    bank_rsp_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      settle();
      chk("t3_stall_valid", 128'(pe_rsp_valid), 128'(1));
      chk("t3_stall_id", 128'(pe_rsp_id), 128'(t2_ids[0]));
      chk("t3_stall_ready", 128'(pe_req_ready), 128'(0));
      step();
    end
    pe_rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("t3_out_valid", 128'(pe_rsp_valid), 128'(1));
      chk("t3_out_id", 128'(pe_rsp_id), 128'(t2_ids[k]));
      chk("t3_out_data", 128'(pe_rsp_data), 128'(dbase + 64'(k)));
      if (k == 1) chk("t2_ready_after_hs", 128'(pe_req_ready), 128'(1));
      step();
    end
    pe_rsp_ready = 1'b0; settle();
    chk("t3_empty", 128'(pe_rsp_valid), 128'(0));
    chk("t3_outstanding", 128'(outstanding), 128'(0));

    // Grant withheld for 6 cycles: address stable, no acceptance; grant accepts same cycle.
    step(); pe_req_valid = 1'b1; pe_req_addr = 8'h77; pe_req_id = 2'd2; settle();
    chk("t4_first_ready", 128'(pe_req_ready), 128'(1));
    step(); pe_req_addr = 8'h78; pe_req_id = 2'd0;
    for (int k = 0; k < 6; k++) begin
      settle();
      chk("t4_wait_valid", 128'(bank_req_valid), 128'(1));
      chk("t4_wait_addr", 128'(bank_req_addr), 128'(8'h77));
      chk("t4_wait_ready", 128'(pe_req_ready), 128'(0));
      step();
    end
    bank_grant = 1'b1; settle();
    chk("t4_grant_ready", 128'(pe_req_ready), 128'(1));
    step(); pe_req_valid = 1'b0; bank_grant = 1'b0; settle();
    chk("t4_next_valid", 128'(bank_req_valid), 128'(1));
    chk("t4_next_addr", 128'(bank_req_addr), 128'(8'h78));
    // Grant of the second request coincides with the response to the first.
    step(); bank_grant = 1'b1; bank_rsp_valid = 1'b1; bank_rsp_data = 64'h1111_2222_3333_4444;
    step(); bank_grant = 1'b0; bank_rsp_data = 64'h5555_6666_7777_8888;
    step(); bank_rsp_valid = 1'b0;
    drain(2);

    // Flush with two requests outstanding.
    step(); pe_req_valid = 1'b1; pe_req_addr = 8'h40; pe_req_id = 2'd1; bank_grant = 1'b1; settle();
    chk("t5_req0_ready", 128'(pe_req_ready), 128'(1));
    step(); pe_req_addr = 8'h41; pe_req_id = 2'd2; settle();
    chk("t5_req1_ready", 128'(pe_req_ready), 128'(1));
    step(); pe_req_valid = 1'b0;
    step(); bank_grant = 1'b0; pe_req_valid = 1'b1; pe_req_addr = 8'h42; pe_req_id = 2'd0;
    flush = 1'b1; settle();
    chk("t5_flush_ready", 128'(pe_req_ready), 128'(0));
    step(); flush = 1'b0; pe_req_valid = 1'b0;
    bank_rsp_valid = 1'b1; bank_rsp_data = 64'hE0E0_E0E0_0000_0000; settle();
    chk("t5_state_drain", 128'(state_dbg), 128'(ST_DRAIN));
    chk("t5_drain_ready", 128'(pe_req_ready), 128'(0));
    chk("t5_done_early0", 128'(flush_done), 128'(0));
    step(); bank_rsp_data = 64'hE1E1_E1E1_0000_0001; settle();
    chk("t5_done_early1", 128'(flush_done), 128'(0));
    step(); bank_rsp_valid = 1'b0; pe_rsp_ready = 1'b1; settle();
    chk("t5_hs0_valid", 128'(pe_rsp_valid), 128'(1));
    chk("t5_done_early2", 128'(flush_done), 128'(0));
    step(); settle();
    chk("t5_hs1_valid", 128'(pe_rsp_valid), 128'(1));
    chk("t5_done_early3", 128'(flush_done), 128'(0));
    step(); pe_rsp_ready = 1'b0; settle();
    chk("t5_done_pulse", 128'(flush_done), 128'(1));
    chk("t5_done_state", 128'(state_dbg), 128'(ST_DRAIN));
    step(); settle();
    chk("t5_done_low", 128'(flush_done), 128'(0));
    chk("t5_idle", 128'(state_dbg), 128'(ST_IDLE));
    chk("t5_ready_back", 128'(pe_req_ready), 128'(1));

    // Unexpected response with nothing outstanding; sticky error.
    step(); bank_rsp_valid = 1'b1; bank_rsp_data = 64'hBAD0; settle();
    chk("t6_err_before", 128'(err_unexp), 128'(0));
    step(); bank_rsp_valid = 1'b0; settle();
    chk("t6_err_set", 128'(err_unexp), 128'(1));
    chk("t6_no_rsp", 128'(pe_rsp_valid), 128'(0));
    repeat (3) step();
    settle();
    chk("t6_err_sticky", 128'(err_unexp), 128'(1));

    // Reset asserted mid-burst.
    step(); pe_req_valid = 1'b1; bank_grant = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pe_req_addr = 8'h60 + 8'(k); pe_req_id = 2'(k);
      step();
    end
    pe_req_valid = 1'b0; bank_rsp_valid = 1'b1; bank_rsp_data = 64'hCC00;
    step(); bank_rsp_data = 64'hCC01; settle();
    chk("t6_burst_rsp", 128'(pe_rsp_valid), 128'(1));
    reset = 1'b0; settle();
    chk_zero("t6_async_reset");
    pe_req_valid = 1'b0; bank_grant = 1'b0; bank_rsp_valid = 1'b0; pe_rsp_ready = 1'b0;
    repeat (2) step();
    reset = 1'b1; settle();
    chk("t6_err_cleared", 128'(err_unexp), 128'(0));
    chk("t6_rel_outstanding", 128'(outstanding), 128'(0));
    chk("t6_rel_breq", 128'(bank_req_valid), 128'(0));
    // A late response for a discarded request is unexpected.
    step(); bank_rsp_valid = 1'b1; bank_rsp_data = 64'hCC02;
    step(); bank_rsp_valid = 1'b0; settle();
    chk("t6_late_err", 128'(err_unexp), 128'(1));
    chk("t6_late_no_rsp", 128'(pe_rsp_valid), 128'(0));

    step();
    chk("exp_q_empty", 128'(exp_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
